// File: rtl/fetch_unit.sv
// fetch_unit: PC, memory address drive, and a one-entry skid buffer in front of decode
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = '1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_target,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic [DATA_W-1:0] pc, req_pc, skid_instr, skid_pc;
  logic req_valid, skid_valid, halt_hit;
  assign halt_hit = req_valid && mem_data == HALT_OPCODE;
  assign mem_addr = redirect ? redirect_target : pc;
  // redirect beats stall beats normal flow; the in-flight word is parked in the skid while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      req_valid <= 1'b0;
      req_pc <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      state <= RUN;
      halted <= 1'b0;
    end else if (redirect) begin
      req_valid <= 1'b1;
      req_pc <= redirect_target;
      pc <= redirect_target + DATA_W'(1);
      skid_valid <= 1'b0;
      instr_valid <= 1'b0;
      state <= RUN;
      halted <= 1'b0;
    end else if (stall) begin
      req_valid <= 1'b0;
      if (req_valid && !skid_valid) begin
        skid_instr <= mem_data;
        skid_pc <= req_pc;
        skid_valid <= 1'b1;
      end
      if (halt_hit) begin
        state <= HALTED;
        halted <= 1'b1;
      end
    end else begin
      if (skid_valid) begin
        instr <= skid_instr;
        instr_pc <= skid_pc;
        instr_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (req_valid) begin
        instr <= mem_data;
        instr_pc <= req_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
      if (state == RUN && !halt_hit) begin
        req_valid <= 1'b1;
        req_pc <= pc;
        pc <= pc + DATA_W'(1);
      end else begin
        req_valid <= 1'b0;
      end
      if (halt_hit) begin
        state <= HALTED;
        halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a synchronous memory model
module tb_fetch_unit;
  logic clk = 0, reset = 1, stall = 0, redirect = 0;
  logic [15:0] redirect_target = '0, mem_data = '0;
  logic [15:0] mem_addr, instr, instr_pc;
  logic instr_valid, halted;
  logic [15:0] mem [0:65535];
  logic [15:0] q[$];
  int n_chk = 0, n_pass = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  // synchronous instruction memory
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // one cycle: check consumption at negedge against the queue, then advance past posedge
  task automatic tick();
    logic [15:0] p;
    @(negedge clk);
    chk("skid_req_excl", 32'(dut.skid_valid & dut.req_valid), 0);
    if (instr_valid && !stall && !redirect && !reset) begin
      if (q.size() == 0) chk("extra_word", 32'(instr_valid), 0);
      else begin
        p = q.pop_front();
        chk("sb_pc", instr_pc, p);
        chk("sb_instr", instr, mem[p]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [15:0] t, input int n);
    redirect = 1;
    redirect_target = t;
    tick();
    redirect = 0;
    stall = 0;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(16'(t + i));
    chk("redir_flush", instr_valid, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_iv", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", mem_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(32'h1000 + i);
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 40; i++) q.push_back(16'(i));
    tick();
    chk("edge1_iv", instr_valid, 0);
    chk("edge1_addr", mem_addr, 1);
    tick();
    chk("first_iv", instr_valid, 1);
    chk("first_instr", instr, 16'h1000);
    chk("first_pc", instr_pc, 0);
    tick();
    tick();
    chk("third_pc", instr_pc, 2);
    stall = 1;
    repeat (3) begin
      tick();
      chk("stall_pc", instr_pc, 2);
      chk("stall_iv", instr_valid, 1);
      chk("stall_addr", mem_addr, 4);
    end
    stall = 0;
    tick();
    chk("release_skid", instr_pc, 3);
    tick();
    chk("release_next", instr_pc, 4);
    tick();
    tick();
    redir(16'h0040, 16);
    tick();
    chk("redir_pc0", instr_pc, 16'h0040);
    chk("redir_instr0", instr, 16'h1040);
    tick();
    chk("redir_pc1", instr_pc, 16'h0041);
    tick();
    stall = 1;
    tick();
    tick();
    redir(16'h0080, 16);
    tick();
    chk("redir_st_pc0", instr_pc, 16'h0080);
    chk("redir_st_iv", instr_valid, 1);
    tick();
    chk("redir_st_pc1", instr_pc, 16'h0081);
    mem[5] = 16'hFFFF;
    redir(16'h0000, 6);
    repeat (6) tick();
    chk("halt_word", instr, 16'hFFFF);
    chk("halt_word_pc", instr_pc, 5);
    chk("halt_rise", halted, 1);
    tick();
    chk("halt_iv", instr_valid, 0);
    chk("halt_hold", halted, 1);
    chk("halt_addr", mem_addr, 6);
    repeat (3) tick();
    chk("halt_addr_late", mem_addr, 6);
    chk("halt_iv_late", instr_valid, 0);
    chk("halt_drain", q.size(), 0);
    mem[5] = 16'h1005;
    redir(16'h0000, 8);
    chk("unhalt", halted, 0);
    tick();
    tick();
    chk("restart_pc", instr_pc, 1);
    redir(16'hFFFF, 4);
    tick();
    chk("wrap_pc0", instr_pc, 16'hFFFF);
    chk("wrap_instr0", instr, 16'h0FFF);
    tick();
    chk("wrap_pc1", instr_pc, 16'h0000);
    chk("wrap_instr1", instr, 16'h1000);
    tick();
    stall = 1;
    tick();
    tick();
    #2;
    reset = 1;
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    reset = 0;
    stall = 0;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(16'(i));
    tick();
    chk("rerun_edge1_iv", instr_valid, 0);
    tick();
    chk("rerun_iv", instr_valid, 1);
    chk("rerun_pc0", instr_pc, 0);
    tick();
    chk("rerun_pc1", instr_pc, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
